// File: rtl/uart_baud_tick_gen_if.sv
// Control and tick bundle of the UART baud tick generator.
// The master drives run control and divisor loads; the slave (the generator) returns ticks and phase.
interface uart_baud_tick_gen_if #(
    parameter int DIV_WIDTH  = 16,
    parameter int FRAC_WIDTH = 4,
    parameter int OVERSAMPLE = 16
);
    localparam int PHASE_W = $clog2(OVERSAMPLE);

    logic                  en;
    logic [DIV_WIDTH-1:0]  div_int;
    logic [FRAC_WIDTH-1:0] div_frac;
    logic                  div_load;
    logic                  sync_clear;
    logic                  os_tick;
    logic                  baud_tick;
    logic                  mid_tick;
    logic [PHASE_W-1:0]    phase;

    modport master (
        output en, div_int, div_frac, div_load, sync_clear,
        input  os_tick, baud_tick, mid_tick, phase
    );

    modport slave (
        input  en, div_int, div_frac, div_load, sync_clear,
        output os_tick, baud_tick, mid_tick, phase
    );
endinterface

// File: rtl/uart_baud_tick_gen.sv
// Fractional-divisor tick generator: oversample, bit-rate and mid-bit enable pulses in the clk domain.
// Divisor loads are double-buffered so a running period is never shortened.
module uart_baud_tick_gen #(
    parameter int DIV_WIDTH    = 16,
    parameter int FRAC_WIDTH   = 4,
    parameter int OVERSAMPLE   = 16,
    parameter int DEFAULT_INT  = 325,
    parameter int DEFAULT_FRAC = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_baud_tick_gen_if.slave bus
);
    localparam int PHASE_W = $clog2(OVERSAMPLE);
    localparam int CNT_W   = DIV_WIDTH + 1;

    logic [DIV_WIDTH-1:0]  sh_int, act_int, sh_int_nxt, eff_int;
    logic [FRAC_WIDTH-1:0] sh_frac, act_frac, sh_frac_nxt, acc;
    logic [FRAC_WIDTH:0]   frac_sum;
    logic [CNT_W-1:0]      cnt, period;
    logic [PHASE_W-1:0]    phase_q;
    logic                  os_q;
    logic                  terminal;

    always_comb begin
        sh_int_nxt  = bus.div_load ? bus.div_int  : sh_int;
        sh_frac_nxt = bus.div_load ? bus.div_frac : sh_frac;
        // A divisor of 0 or 1 would make back-to-back or stuck ticks.
        eff_int     = (act_int < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : act_int;
        frac_sum    = {1'b0, acc} + {1'b0, act_frac};
        period      = {1'b0, eff_int} + CNT_W'(frac_sum[FRAC_WIDTH]);
        terminal    = (cnt == CNT_W'(1));
    end

    // cnt == 0 is the start state: the next enabled edge begins a period and
    // loads period-1, so the terminating edge lands exactly 'period' edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_int   <= DIV_WIDTH'(DEFAULT_INT);
            sh_frac  <= FRAC_WIDTH'(DEFAULT_FRAC);
            act_int  <= DIV_WIDTH'(DEFAULT_INT);
            act_frac <= FRAC_WIDTH'(DEFAULT_FRAC);
            cnt      <= '0;
            acc      <= '0;
            phase_q  <= '0;
            os_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values,
            // so the order of these statements does not change the result.
            sh_int  <= sh_int_nxt;
            sh_frac <= sh_frac_nxt;
            if (bus.sync_clear || !bus.en) begin
                cnt      <= '0;
                acc      <= '0;
                phase_q  <= '0;
                os_q     <= 1'b0;
                act_int  <= sh_int_nxt;
                act_frac <= sh_frac_nxt;
            end else begin
                os_q <= terminal;
                if (os_q) begin
                    phase_q <= phase_q + PHASE_W'(1);
                end
                if (cnt == '0) begin
                    cnt <= period - CNT_W'(1);
                    acc <= frac_sum[FRAC_WIDTH-1:0];
                end else begin
                    cnt <= cnt - CNT_W'(1);
                    if (terminal) begin
                        act_int  <= sh_int_nxt;
                        act_frac <= sh_frac_nxt;
                    end
                end
            end
        end
    end

    assign bus.os_tick   = os_q;
    assign bus.phase     = phase_q;
    assign bus.baud_tick = os_q && (phase_q == PHASE_W'(OVERSAMPLE - 1));
    assign bus.mid_tick  = os_q && (phase_q == PHASE_W'(OVERSAMPLE / 2 - 1));
endmodule
